// File: rtl/hworld_seq_adder.sv
// Memory-mapped multi-cycle WIDTH-bit add/subtract/accumulate engine with an OBI slave port.
// The adder processes CHUNK bits per cycle and keeps the carry in a register between chunks.
module hworld_seq_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic [AW-1:0] addr_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic          rvalid_o,
  output logic [31:0]   rdata_o,
  output logic          irq_o
);

  localparam int NW  = WIDTH / 32;
  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW  = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q, op_a_q, op_b_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic             acc_q, sub_q, irq_en_q;
  logic             done_q, cout_q, ovf_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;

  // OBI handshake: every request is granted in the same cycle (gnt = req); a
  // granted cycle yields exactly one rvalid pulse on the following cycle, for
  // reads and writes alike, with registered rdata (0 for writes).
  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign irq_o    = done_q & irq_en_q;

  logic [7:0] off;
  logic [1:0] widx;
  logic       aligned, sel_a, sel_b, sel_sum, sel_ctrl, sel_stat;
  logic       wr, rd, start, last, w1c, busy;

  assign off      = addr_i[7:0];
  assign widx     = off[3:2];
  assign aligned  = (off[1:0] == 2'b00);
  assign sel_a    = aligned && (off[7:4] == 4'h0);
  assign sel_b    = aligned && (off[7:4] == 4'h1);
  assign sel_sum  = aligned && (off[7:4] == 4'h2);
  assign sel_ctrl = (off == 8'h30);
  assign sel_stat = (off == 8'h34);

  assign wr    = req_i & we_i;
  assign rd    = req_i & ~we_i;
  assign busy  = (state_q == RUN);
  assign start = wr && sel_ctrl && be_i[0] && wdata_i[0] && !busy;
  assign last  = busy && (k_q == KW'(NCH - 1));
  assign w1c   = wr && sel_stat && be_i[0] && wdata_i[1];

  // One chunk of the ripple: bit offset of chunk k, operand slices and their sum.
  logic [IW-1:0]    base;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   ch_sum;

  assign base   = IW'(k_q) * IW'(CHUNK);
  assign a_ch   = op_a_q[base +: CHUNK];
  assign b_ch   = op_b_q[base +: CHUNK];
  assign ch_sum = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NW; i++) begin
      if (widx == 2'(i)) begin
        if (sel_a)   rd_val = a_q[i*32 +: 32];
        if (sel_b)   rd_val = b_q[i*32 +: 32];
        if (sel_sum) rd_val = sum_q[i*32 +: 32];
      end
    end
    if (sel_ctrl) rd_val = {28'b0, irq_en_q, sub_q, acc_q, 1'b0};
    if (sel_stat) rd_val = {28'b0, ovf_q, cout_q, done_q, busy};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      acc_q    <= 1'b0;
      sub_q    <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= rd ? rd_val : '0;

      // Operand and control writes are only accepted while idle.
      if (wr && !busy) begin
        for (int i = 0; i < NW; i++) begin
          for (int b = 0; b < 4; b++) begin
            if (be_i[b] && (widx == 2'(i))) begin
              if (sel_a) a_q[i*32 + b*8 +: 8] <= wdata_i[b*8 +: 8];
              if (sel_b) b_q[i*32 + b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
          end
        end
        if (sel_ctrl && be_i[0]) begin
          acc_q    <= wdata_i[1];
          sub_q    <= wdata_i[2];
          irq_en_q <= wdata_i[3];
        end
      end

      if (w1c) done_q <= 1'b0;

      // Launch uses the mode bits carried by the START write itself.
      if (start) begin
        k_q     <= '0;
        carry_q <= wdata_i[2];
        done_q  <= 1'b0;
        op_a_q  <= wdata_i[1] ? sum_q : a_q;
        op_b_q  <= wdata_i[2] ? ~b_q : b_q;
      end

      if (busy) begin
        sum_q[base +: CHUNK] <= ch_sum[CHUNK-1:0];
        carry_q              <= ch_sum[CHUNK];
        k_q                  <= k_q + KW'(1);
        // Done set is placed after the W1C so it wins on a same-cycle clear.
        if (last) begin
          cout_q <= ch_sum[CHUNK];
          ovf_q  <= (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                    (ch_sum[CHUNK-1] != op_a_q[WIDTH-1]);
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hworld_seq_adder.sv
// Self-checking bench for hworld_seq_adder: directed vector table, multi-cycle corner
// sequences, and random operations checked against an arithmetic reference model.
module tb_hworld_seq_adder;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int NW    = WIDTH / 32;
  localparam int NCH   = WIDTH / CHUNK;

  localparam logic [7:0] A_OFF    = 8'h00;
  localparam logic [7:0] B_OFF    = 8'h10;
  localparam logic [7:0] SUM_OFF  = 8'h20;
  localparam logic [7:0] CTRL_OFF = 8'h30;
  localparam logic [7:0] STAT_OFF = 8'h34;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [7:0]  addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt, rvalid, irq;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hworld_seq_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK), .AW(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .irq_o    (irq)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic and signed-range overflow.
  function automatic void ref_op(input logic acc, input logic sub,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] sum,
                                 output logic [WIDTH-1:0] res, output logic cout, output logic ovf);
    logic [WIDTH-1:0]        opa;
    logic [WIDTH:0]          u;
    logic signed [WIDTH:0]   s;
    opa = acc ? sum : a;
    if (sub) begin
      res  = opa - b;
      cout = (opa >= b);
      s    = $signed({opa[WIDTH-1], opa}) - $signed({b[WIDTH-1], b});
    end else begin
      u    = {1'b0, opa} + {1'b0, b};
      res  = u[WIDTH-1:0];
      cout = u[WIDTH];
      s    = $signed({opa[WIDTH-1], opa}) + $signed({b[WIDTH-1], b});
    end
    ovf = (s[WIDTH] != s[WIDTH-1]);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; the access is granted at the next rising edge and
  // the response is sampled at the following falling edge.
  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] r);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    check("gnt", gnt, 1'b1);
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = 4'h0;
    check("rvalid", rvalid, 1'b1);
    r = rdata;
    if (w) check("wr_rdata", rdata, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, 4'hF, r);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    bus(1'b0, a, 32'h0, 4'h0, r);
  endtask

  task automatic write_wide(input logic [7:0] base, input logic [WIDTH-1:0] v);
    for (int i = 0; i < NW; i++) wr(base + 8'(4*i), v[i*32 +: 32]);
  endtask

  task automatic read_wide(input logic [7:0] base, output logic [WIDTH-1:0] v);
    logic [31:0] r;
    for (int i = 0; i < NW; i++) begin
      rd(base + 8'(4*i), r);
      v[i*32 +: 32] = r;
    end
  endtask

  task automatic wait_done();
    logic [31:0] r;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 4*NCH + 8 && !ok; n++) begin
      rd(STAT_OFF, r);
      if (!r[0]) ok = 1'b1;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_done: busy=1 after %0d polls, want 0", 4*NCH + 8);
    end
  endtask

  task automatic run_op(input logic acc, input logic sub, input logic irq_en);
    wr(CTRL_OFF, {28'b0, irq_en, sub, acc, 1'b1});
    wait_done();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      r;
    logic [WIDTH-1:0] v, a_r, b_r, sum_m, e_sum;
    logic             e_cout, e_ovf, acc_r, sub_r;

    vecs[0] = '{1'b0, 64'h0000_0001_FFFF_FFFF, 64'h1, 64'h0000_0002_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 64'h5, 64'h3, 64'h2, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 64'h0000_FFFF_0000_FFFF, 64'h1, 64'h0000_FFFF_0001_0000, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 64'h0000_FFFF_FFFF_FFFF, 64'h1, 64'h0001_0000_0000_0000, 1'b0, 1'b0};

    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 0);
    check("rst_irq", irq, 1'b0);
    check("rst_gnt_idle", gnt, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Every offset including unmapped 0x40 reads zero after reset.
    for (int o = 0; o <= 8'h40; o += 4) begin
      rd(8'(o), r);
      check($sformatf("reset_rd_%0h", o), r, 0);
    end
    check("reset_irq", irq, 1'b0);
    @(negedge clk);
    check("rvalid_single", rvalid, 1'b0);

    // Byte enables on operand writes.
    wr(A_OFF, 32'hAABB_CCDD);
    bus(1'b1, A_OFF, 32'h1122_3344, 4'b0101, r);
    rd(A_OFF, r);
    check("byte_enable", r, 32'hAA22_CC44);

    // Latency: busy exactly NCH cycles, then done.
    write_wide(A_OFF, 64'h0000_0001_FFFF_FFFF);
    write_wide(B_OFF, 64'h1);
    wr(CTRL_OFF, 32'h1);
    for (int c = 1; c <= NCH + 2; c++) begin
      rd(STAT_OFF, r);
      check($sformatf("lat_busy_c%0d", c), r[0], (c <= NCH));
      check($sformatf("lat_done_c%0d", c), r[1], (c > NCH));
    end
    read_wide(SUM_OFF, v);
    check("lat_sum", v, 64'h0000_0002_0000_0000);
    check("lat_cout", r[2], 1'b0);
    check("lat_ovf", r[3], 1'b0);

    // Directed vector table.
    foreach (vecs[i]) begin
      write_wide(A_OFF, vecs[i].a);
      write_wide(B_OFF, vecs[i].b);
      run_op(1'b0, vecs[i].sub, 1'b0);
      read_wide(SUM_OFF, v);
      rd(STAT_OFF, r);
      check($sformatf("vec%0d_sum", i), v, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), r[2], vecs[i].cout);
      check($sformatf("vec%0d_ovf", i), r[3], vecs[i].ovf);
      check($sformatf("vec%0d_done", i), r[1], 1'b1);
    end

    // Accumulate: clear SUM with 0+0, then SUM += 5 three times, then SUM -= 4.
    write_wide(A_OFF, 64'h0);
    write_wide(B_OFF, 64'h0);
    run_op(1'b0, 1'b0, 1'b0);
    write_wide(B_OFF, 64'h5);
    repeat (3) run_op(1'b1, 1'b0, 1'b0);
    read_wide(SUM_OFF, v);
    check("acc_sum15", v, 64'd15);
    write_wide(B_OFF, 64'h4);
    run_op(1'b1, 1'b1, 1'b0);
    read_wide(SUM_OFF, v);
    check("acc_sub_sum11", v, 64'd11);

    // Writes and a second START during RUN are acknowledged but discarded.
    write_wide(A_OFF, 64'd10);
    write_wide(B_OFF, 64'd5);
    wr(CTRL_OFF, 32'h1);
    wr(A_OFF, 32'h1234);
    wr(CTRL_OFF, 32'hF);
    wait_done();
    read_wide(SUM_OFF, v);
    check("run_ign_sum", v, 64'd15);
    rd(A_OFF, r);
    check("run_ign_a", r, 32'd10);
    rd(CTRL_OFF, r);
    check("run_ign_ctrl", r, 32'h0);
    rd(STAT_OFF, r);
    check("run_ign_idle", r[0], 1'b0);

    // IRQ plus W1C landing on the done-set cycle.
    write_wide(A_OFF, 64'd1);
    write_wide(B_OFF, 64'd2);
    wr(CTRL_OFF, 32'h9);
    for (int c = 1; c < NCH; c++) rd(STAT_OFF, r);
    wr(STAT_OFF, 32'h2);
    rd(STAT_OFF, r);
    check("w1c_race_done", r[1], 1'b1);
    check("irq_set", irq, 1'b1);
    bus(1'b1, STAT_OFF, 32'h2, 4'h0, r);
    check("w1c_be_gated", irq, 1'b1);
    wr(STAT_OFF, 32'h2);
    check("irq_clear", irq, 1'b0);
    rd(STAT_OFF, r);
    check("w1c_done_clr", r[1], 1'b0);
    read_wide(SUM_OFF, sum_m);
    check("irq_op_sum", sum_m, 64'd3);

    // Random operations against the reference model.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NW; i++) begin
        a_r[i*32 +: 32] = $urandom();
        b_r[i*32 +: 32] = $urandom();
      end
      if ($urandom_range(0, 3) == 0) b_r[WIDTH-1 -: 8] = 8'h00;
      acc_r = 1'($urandom_range(0, 1));
      sub_r = 1'($urandom_range(0, 1));
      ref_op(acc_r, sub_r, a_r, b_r, sum_m, e_sum, e_cout, e_ovf);
      exp_q.push_back(e_sum);
      write_wide(A_OFF, a_r);
      write_wide(B_OFF, b_r);
      run_op(acc_r, sub_r, 1'b0);
      read_wide(SUM_OFF, v);
      rd(STAT_OFF, r);
      check($sformatf("rnd%0d_sum", n), v, exp_q.pop_front());
      check($sformatf("rnd%0d_cout", n), r[2], e_cout);
      check($sformatf("rnd%0d_ovf", n), r[3], e_ovf);
      sum_m = e_sum;
    end

    // Asynchronous reset while chunk k=2 is in flight.
    write_wide(A_OFF, 64'h1111_1111_1111_1111);
    write_wide(B_OFF, 64'h1111_1111_1111_1111);
    wr(CTRL_OFF, 32'h9);
    rd(STAT_OFF, r);
    rd(STAT_OFF, r);
    check("pre_rst_busy", r[0], 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_rvalid", rvalid, 1'b0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_irq", irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rd(STAT_OFF, r);
    check("post_rst_status", r, 32'h0);
    read_wide(SUM_OFF, v);
    check("post_rst_sum", v, 64'h0);
    rd(A_OFF, r);
    check("post_rst_a", r, 32'h0);

    write_wide(A_OFF, 64'd3);
    write_wide(B_OFF, 64'd4);
    run_op(1'b0, 1'b0, 1'b0);
    read_wide(SUM_OFF, v);
    check("post_rst_op_sum", v, 64'd7);
    rd(STAT_OFF, r);
    check("post_rst_op_done", r[1], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
